// File: rtl/sat2_enum_solver.sv
// Brute-force 2-SAT solver: clause RAM plus a candidate enumerator
// that scans one clause per cycle until a model is found or all fail.
module sat2_enum_solver #(
  parameter int NVARS       = 3,
  parameter int MAX_CLAUSES = 16,
  parameter int AW          = 4,
  parameter int LIT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [LIT_W-1:0] var1,
  input  logic [LIT_W-1:0] var2,
  input  logic [AW:0]      num_clauses,
  input  logic             done,
  input  logic [AW-1:0]    rd_addr,
  output logic [LIT_W-1:0] rd_var1,
  output logic [LIT_W-1:0] rd_var2,
  output logic             busy,
  output logic             done2,
  output logic             sat,
  output logic             err,
  output logic [NVARS-1:0] assign_out,
  output logic [15:0]      cycles
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [2*LIT_W-1:0] ram_q [MAX_CLAUSES];

  logic [AW:0]      n_q, n_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [NVARS-1:0] cand_q, cand_d;
  logic             sat_q, sat_d;
  logic             err_q, err_d;
  logic [NVARS-1:0] asg_q, asg_d;
  logic [15:0]      cyc_q, cyc_d;

  logic             wr_ok;
  logic [AW:0]      n_clamp;
  logic [2*LIT_W-1:0] clause;
  logic             clause_true;
  logic             last;

  // Magnitude is one bit wider so the most negative literal cannot wrap.
  function automatic logic [LIT_W:0] lit_mag(input logic [LIT_W-1:0] l);
    logic [LIT_W:0] m;
    if (l[LIT_W-1]) m = ~{1'b1, l} + 1'b1;
    else            m = {1'b0, l};
    return m;
  endfunction

  function automatic logic lit_bad(input logic [LIT_W-1:0] l);
    return (l == '0) || (lit_mag(l) > (LIT_W+1)'(NVARS));
  endfunction

  function automatic logic lit_true(
    input logic [LIT_W-1:0] l,
    input logic [NVARS-1:0] c
  );
    logic [LIT_W:0] m;
    logic           v;
    m = lit_mag(l);
    v = 1'b0;
    for (int i = 0; i < NVARS; i++) begin
      if (m == (LIT_W+1)'(i + 1)) v = c[i];
    end
    return l[LIT_W-1] ? ~v : v;
  endfunction

  assign wr_ok = (state_q == S_IDLE) && we &&
                 ({1'b0, addr} < (AW+1)'(MAX_CLAUSES));

  always_ff @(posedge clk) begin
    if (wr_ok) ram_q[addr] <= {var1, var2};
  end

  assign rd_var1 = ram_q[rd_addr][2*LIT_W-1:LIT_W];
  assign rd_var2 = ram_q[rd_addr][LIT_W-1:0];

  assign n_clamp = (num_clauses > (AW+1)'(MAX_CLAUSES)) ?
                   (AW+1)'(MAX_CLAUSES) : num_clauses;

  assign clause      = ram_q[idx_q];
  assign clause_true = lit_true(clause[2*LIT_W-1:LIT_W], cand_q) |
                       lit_true(clause[LIT_W-1:0], cand_q);
  assign last        = ({1'b0, idx_q} == (n_q - 1'b1));

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    cand_d  = cand_q;
    sat_d   = sat_q;
    asg_d   = asg_q;
    cyc_d   = cyc_q;
    err_d   = err_q |
              (wr_ok && (lit_bad(var1) || lit_bad(var2)));
    unique case (state_q)
      S_IDLE: begin
        if (done && !we) begin
          n_d     = n_clamp;
          idx_d   = '0;
          cand_d  = '0;
          cyc_d   = '0;
          asg_d   = '0;
          sat_d   = 1'b0;
          state_d = S_DONE;
          if (err_q)               sat_d   = 1'b0;
          else if (n_clamp == '0)  sat_d   = 1'b1;
          else                     state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        cyc_d = (&cyc_q) ? cyc_q : cyc_q + 16'd1;
        if (!clause_true) begin
          if (&cand_q) begin
            sat_d   = 1'b0;
            state_d = S_DONE;
          end else begin
            cand_d = cand_q + 1'b1;
            idx_d  = '0;
          end
        end else if (last) begin
          sat_d   = 1'b1;
          asg_d   = cand_q;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      idx_q   <= '0;
      cand_q  <= '0;
      sat_q   <= 1'b0;
      err_q   <= 1'b0;
      asg_q   <= '0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      cand_q  <= cand_d;
      sat_q   <= sat_d;
      err_q   <= err_d;
      asg_q   <= asg_d;
      cyc_q   <= cyc_d;
    end
  end

  assign busy       = (state_q == S_CHECK);
  assign done2      = (state_q == S_DONE);
  assign sat        = sat_q;
  assign err        = err_q;
  assign assign_out = asg_q;
  assign cycles     = cyc_q;

endmodule

// File: tb/tb_sat2_enum_solver.sv
// Bench for sat2_enum_solver: directed vector table, corner sequences,
// and random clause sets against a brute-force enumeration model.
module tb_sat2_enum_solver;
  localparam int NV = 3;
  localparam int MC = 16;
  localparam int AW = 4;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          we;
  logic [AW-1:0] addr;
  logic [LW-1:0] var1, var2;
  logic [AW:0]   num_clauses;
  logic          done;
  logic [AW-1:0] rd_addr;
  logic [LW-1:0] rd_var1, rd_var2;
  logic          busy, done2, sat, err;
  logic [NV-1:0] assign_out;
  logic [15:0]   cycles;

  sat2_enum_solver #(
    .NVARS(NV), .MAX_CLAUSES(MC), .AW(AW), .LIT_W(LW)
  ) dut (
    .clk(clk), .reset(reset), .we(we), .addr(addr),
    .var1(var1), .var2(var2), .num_clauses(num_clauses),
    .done(done), .rd_addr(rd_addr), .rd_var1(rd_var1),
    .rd_var2(rd_var2), .busy(busy), .done2(done2), .sat(sat),
    .err(err), .assign_out(assign_out), .cycles(cycles)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic signed [7:0] ma [MC];
  logic signed [7:0] mb [MC];

  typedef struct {
    int             nc;
    logic [3:0][7:0] a;
    logic [3:0][7:0] b;
    int             num;
    bit             s;
    int             asg;
    int             cyc;
    int             lat;
  } vec_t;

  vec_t vt [3];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [7:0] v1,
                    input logic [7:0] v2);
    we   = 1'b1;
    addr = AW'(a);
    var1 = v1;
    var2 = v2;
    tick();
    we = 1'b0;
    ma[a] = v1;
    mb[a] = v2;
  endtask

  // lat = ticks from the start edge (1) until done2 is observed
  task automatic run_solve(input int num, output int lat,
                           output bit busy_seen);
    done        = 1'b1;
    num_clauses = (AW+1)'(num);
    lat         = 0;
    busy_seen   = 1'b0;
    for (int i = 1; i <= 400; i++) begin
      tick();
      if (i == 1) done = 1'b0;
      if (busy) busy_seen = 1'b1;
      if (done2) begin
        lat = i;
        break;
      end
    end
    done = 1'b0;
    if (lat == 0) begin
      errors++;
      $display("FAIL solve_timeout: got no done2 expected done2");
    end
    tick();
    chk("done2_pulse", done2, 0);
  endtask

  function automatic bit lt(input logic signed [7:0] l, input int c);
    int k;
    bit v;
    k = (l < 0) ? -int'(l) : int'(l);
    v = c[k-1];
    return (l > 0) ? v : !v;
  endfunction

  // Enumerate candidates in ascending order, counting one cycle per
  // clause evaluated, stopping at the first false clause.
  function automatic void model(input int num, output bit s,
                                output int asg, output int cyc);
    int  n;
    bit  ok;
    n   = (num > MC) ? MC : num;
    cyc = 0;
    s   = 1'b0;
    asg = 0;
    for (int c = 0; c < (1 << NV); c++) begin
      ok = 1'b1;
      for (int i = 0; i < n; i++) begin
        cyc++;
        if (!(lt(ma[i], c) || lt(mb[i], c))) begin
          ok = 1'b0;
          break;
        end
      end
      if (ok) begin
        s   = 1'b1;
        asg = c;
        return;
      end
    end
  endfunction

  function automatic logic [7:0] rl();
    int k;
    logic signed [7:0] v;
    k = $urandom_range(1, NV);
    v = 8'(k);
    if ($urandom_range(0, 1) == 1) v = -v;
    return v;
  endfunction

  initial begin
    int  lat;
    bit  bs;
    int  n, num, masg, mcyc, dn;
    bit  ms;

    reset = 1'b1; we = 1'b0; addr = '0; var1 = '0; var2 = '0;
    num_clauses = '0; done = 1'b0; rd_addr = '0;

    vt[0].nc = 4; vt[0].num = 4;
    vt[0].a = {8'sd3, -8'sd1, 8'sd2, 8'sd1};
    vt[0].b = {8'sd2, 8'sd3, -8'sd3, -8'sd2};
    vt[0].s = 1; vt[0].asg = 7; vt[0].cyc = 20; vt[0].lat = 21;
    vt[1].nc = 2; vt[1].num = 2;
    vt[1].a = {8'sd0, 8'sd0, -8'sd1, 8'sd1};
    vt[1].b = {8'sd0, 8'sd0, -8'sd1, 8'sd1};
    vt[1].s = 0; vt[1].asg = 0; vt[1].cyc = 12; vt[1].lat = 13;
    vt[2].nc = 0; vt[2].num = 0;
    vt[2].a = '0; vt[2].b = '0;
    vt[2].s = 1; vt[2].asg = 0; vt[2].cyc = 0; vt[2].lat = 1;

    tick(); tick();
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done2", done2, 0);
    chk("rst_sat", sat, 0);
    chk("rst_err", err, 0);
    chk("rst_assign", assign_out, 0);
    chk("rst_cycles", cycles, 0);

    for (int v = 0; v < 3; v++) begin
      for (int j = 0; j < vt[v].nc; j++) wr(j, vt[v].a[j], vt[v].b[j]);
      run_solve(vt[v].num, lat, bs);
      chk("vec_sat", sat, 32'(vt[v].s));
      if (vt[v].s) chk("vec_assign", assign_out, vt[v].asg);
      chk("vec_cycles", cycles, vt[v].cyc);
      chk("vec_latency", lat, vt[v].lat);
      if (vt[v].nc > 0) begin
        rd_addr = '0;
        #1;
        chk("vec_rd_var1", rd_var1, 32'(vt[v].a[0]));
        chk("vec_rd_var2", rd_var2, 32'(vt[v].b[0]));
      end
    end

    // Writes during CHECK are ignored; reset aborts the solve.
    for (int j = 0; j < 4; j++) wr(j, vt[0].a[j], vt[0].b[j]);
    done = 1'b1; num_clauses = 5'd4;
    tick();
    done = 1'b0;
    tick(); tick();
    chk("mid_busy", busy, 1);
    we = 1'b1; addr = '0; var1 = 8'd5; var2 = 8'd5;
    tick();
    we = 1'b0;
    rd_addr = '0;
    #1;
    chk("mid_wr_ignored", rd_var1, 1);
    chk("mid_err_clear", err, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_sat", sat, 0);
    chk("abort_cycles", cycles, 0);
    dn = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (done2 || busy) dn++;
    end
    chk("abort_quiet", dn, 0);

    // Simultaneous write and start: write wins.
    we = 1'b1; done = 1'b1; addr = 4'd1; num_clauses = 5'd4;
    var1 = 8'sd2; var2 = -8'sd3;
    tick();
    we = 1'b0; done = 1'b0;
    chk("wdone_busy0", busy, 0);
    tick();
    chk("wdone_busy1", busy | done2, 0);
    rd_addr = 4'd1;
    #1;
    chk("wdone_rd1", rd_var1, 8'h02);
    chk("wdone_rd2", rd_var2, 8'hFD);
    run_solve(4, lat, bs);
    chk("wdone_sat", sat, 1);
    chk("wdone_assign", assign_out, 7);
    chk("wdone_cycles", cycles, 20);
    chk("wdone_lat", lat, 21);

    for (int it = 0; it < 40; it++) begin
      n = $urandom_range(1, MC);
      for (int j = 0; j < n; j++) wr(j, rl(), rl());
      num = n;
      if (n == MC && $urandom_range(0, 1) == 1) num = 31;
      model(num, ms, masg, mcyc);
      run_solve(num, lat, bs);
      chk("rnd_sat", sat, 32'(ms));
      if (ms) chk("rnd_assign", assign_out, masg);
      chk("rnd_cycles", cycles, mcyc);
      chk("rnd_latency", lat, mcyc + 1);
    end

    wr(0, 8'sd0, 8'sd2);
    chk("err_zero", err, 1);
    run_solve(4, lat, bs);
    chk("err_lat", lat, 1);
    chk("err_busy", bs, 0);
    chk("err_sat", sat, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("err_reset", err, 0);
    wr(0, -8'sd3, 8'sd3);
    chk("err_legal", err, 0);
    wr(2, 8'sd1, -8'sd4);
    chk("err_range", err, 1);
    wr(3, 8'sd1, 8'sd2);
    chk("err_sticky", err, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
